// File: rtl/code_tracker.sv
// code_tracker: registered per-code occurrence counts, run-length tracking and 11->01->00 sequence detection.
module code_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [1:0]       code,
  input  logic             code_vld,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] max_run,
  output logic             det,
  output logic [CNT_W-1:0] det_cnt,
  output logic [1:0]       fsm_st
);
  typedef enum logic [1:0] {IDLE = 2'd0, S_11 = 2'd1, S_1101 = 2'd2} st_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] run_q, run_d, max_q, max_d, det_cnt_q, det_cnt_d;
  logic             det_q, det_d, first_q, first_d;
  logic [1:0]       last_q, last_d;
  st_t              st_q, st_d;
  logic             hit;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + ONE;
  endfunction
  always_comb begin
    st_d = st_q;
    hit  = 1'b0;
    case (st_q)
      IDLE:    st_d = code == 2'b11 ? S_11 : IDLE;
      S_11:    st_d = code == 2'b11 ? S_11 : code == 2'b01 ? S_1101 : IDLE;
      S_1101: begin
        st_d = code == 2'b11 ? S_11 : IDLE;
        hit  = code == 2'b00;
      end
      default: st_d = IDLE;
    endcase
  end
  // clr wins over a same-cycle beat; idle cycles only drop det
  always_comb begin
    cnt_d     = cnt_q;
    run_d     = run_q;
    max_d     = max_q;
    det_cnt_d = det_cnt_q;
    det_d     = 1'b0;
    first_d   = first_q;
    last_d    = last_q;
    if (clr) begin
      cnt_d     = '{default: '0};
      run_d     = '0;
      max_d     = '0;
      det_cnt_d = '0;
      first_d   = 1'b1;
      last_d    = 2'b00;
    end else if (code_vld) begin
      cnt_d[code] = sat_inc(cnt_q[code]);
      run_d       = (first_q || code != last_q) ? ONE : sat_inc(run_q);
      max_d       = run_d > max_q ? run_d : max_q;
      first_d     = 1'b0;
      last_d      = code;
      det_d       = hit;
      det_cnt_d   = hit ? sat_inc(det_cnt_q) : det_cnt_q;
    end
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q     <= '{default: '0};
      run_q     <= '0;
      max_q     <= '0;
      det_cnt_q <= '0;
      det_q     <= 1'b0;
      first_q   <= 1'b1;
      last_q    <= 2'b00;
      st_q      <= IDLE;
    end else begin
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      max_q     <= max_d;
      det_cnt_q <= det_cnt_d;
      det_q     <= det_d;
      first_q   <= first_d;
      last_q    <= last_d;
      st_q      <= clr ? IDLE : code_vld ? st_d : st_q;
    end
  end
  assign cnt0    = cnt_q[0];
  assign cnt1    = cnt_q[1];
  assign cnt2    = cnt_q[2];
  assign cnt3    = cnt_q[3];
  assign run_len = run_q;
  assign max_run = max_q;
  assign det     = det_q;
  assign det_cnt = det_cnt_q;
  assign fsm_st  = st_q;
endmodule

// File: tb/tb_code_tracker.sv
// tb_code_tracker: directed tests of code_tracker at CNT_W=8 and CNT_W=4 sharing one stimulus.
module tb_code_tracker;
  logic clk = 1'b0, rst_b = 1'b0, code_vld = 1'b0, clr = 1'b0;
  logic [1:0] code = 2'b00;
  logic [7:0] a0, a1, a2, a3, arun, amax, adc;
  logic [3:0] b0, b1, b2, b3, brun, bmax, bdc;
  logic adet, bdet;
  logic [1:0] ast, bst;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  code_tracker #(.CNT_W(8)) u8 (.clk(clk), .rst_b(rst_b), .code(code), .code_vld(code_vld), .clr(clr),
    .cnt0(a0), .cnt1(a1), .cnt2(a2), .cnt3(a3), .run_len(arun), .max_run(amax), .det(adet), .det_cnt(adc), .fsm_st(ast));
  code_tracker #(.CNT_W(4)) u4 (.clk(clk), .rst_b(rst_b), .code(code), .code_vld(code_vld), .clr(clr),
    .cnt0(b0), .cnt1(b1), .cnt2(b2), .cnt3(b3), .run_len(brun), .max_run(bmax), .det(bdet), .det_cnt(bdc), .fsm_st(bst));
  task automatic beat(input logic [1:0] c);
    code = c;
    code_vld = 1'b1;
    @(posedge clk);
    #1 code_vld = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask
  task automatic test_reset();
    #12;
    n_cmp++;
    if ({a0, a1, a2, a3, arun, amax, adet, adc, ast} !== '0) begin
      n_fail++;
      $display("FAIL reset: got %h want 0", {a0, a1, a2, a3, arun, amax, adet, adc, ast});
    end
    rst_b = 1'b1;
    #1;
  endtask
  task automatic test_truth_table();
    logic [1:0] seq [8] = '{2'b11, 2'b01, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
    logic seen = 1'b0;
    foreach (seq[i]) begin
      beat(seq[i]);
      seen |= adet;
    end
    n_cmp++;
    if ({a0, a1, a2, a3} !== {8'd3, 8'd1, 8'd0, 8'd4}) begin
      n_fail++;
      $display("FAIL tt_counts: got %0d %0d %0d %0d want 3 1 0 4", a0, a1, a2, a3);
    end
    n_cmp++;
    if ({arun, amax} !== {8'd2, 8'd2}) begin
      n_fail++;
      $display("FAIL tt_runs: got run=%0d max=%0d want 2 2", arun, amax);
    end
    n_cmp++;
    if ({seen, adc, ast} !== {1'b0, 8'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL tt_det: got seen=%b det_cnt=%0d st=%0d want 0 0 0", seen, adc, ast);
    end
  endtask
  task automatic test_detect_gaps();
    do_clr();
    beat(2'b11); beat(2'b11); beat(2'b01);
    idle(3);
    n_cmp++;
    if ({adet, ast} !== {1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL gap_hold: got det=%b st=%0d want 0 2", adet, ast);
    end
    beat(2'b00);
    n_cmp++;
    if ({adet, adc, ast} !== {1'b1, 8'd1, 2'd0}) begin
      n_fail++;
      $display("FAIL gap_det1: got det=%b cnt=%0d st=%0d want 1 1 0", adet, adc, ast);
    end
    idle(1);
    n_cmp++;
    if (adet !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_pulse1: got det=%b want 0", adet);
    end
    beat(2'b11); beat(2'b01);
    idle(3);
    beat(2'b00);
    n_cmp++;
    if ({adet, adc} !== {1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL gap_det2: got det=%b cnt=%0d want 1 2", adet, adc);
    end
    idle(1);
    n_cmp++;
    if ({adet, adc} !== {1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL gap_pulse2: got det=%b cnt=%0d want 0 2", adet, adc);
    end
  endtask
  task automatic test_no_detect();
    logic [1:0] seq [8] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    logic seen = 1'b0;
    do_clr();
    foreach (seq[i]) begin
      beat(seq[i]);
      seen |= adet;
    end
    n_cmp++;
    if ({seen, adc, ast} !== {1'b0, 8'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL nodet: got seen=%b cnt=%0d st=%0d want 0 0 0", seen, adc, ast);
    end
  endtask
  task automatic test_saturation();
    do_clr();
    repeat (20) beat(2'b10);
    n_cmp++;
    if ({b2, brun, bmax} !== {4'd15, 4'd15, 4'd15}) begin
      n_fail++;
      $display("FAIL sat4: got cnt2=%0d run=%0d max=%0d want 15 15 15", b2, brun, bmax);
    end
    n_cmp++;
    if ({a2, arun} !== {8'd20, 8'd20}) begin
      n_fail++;
      $display("FAIL sat8: got cnt2=%0d run=%0d want 20 20", a2, arun);
    end
    beat(2'b01);
    n_cmp++;
    if ({brun, bmax, b1, b2} !== {4'd1, 4'd15, 4'd1, 4'd15}) begin
      n_fail++;
      $display("FAIL sat_break: got run=%0d max=%0d cnt1=%0d cnt2=%0d want 1 15 1 15", brun, bmax, b1, b2);
    end
  endtask
  task automatic test_clr_priority();
    do_clr();
    beat(2'b11); beat(2'b01);
    clr = 1'b1;
    beat(2'b00);
    clr = 1'b0;
    n_cmp++;
    if ({a0, a1, a2, a3, arun, amax, adet, adc, ast} !== '0) begin
      n_fail++;
      $display("FAIL clr_all: got %h want 0", {a0, a1, a2, a3, arun, amax, adet, adc, ast});
    end
    beat(2'b00);
    n_cmp++;
    if ({a0, arun, amax, adet} !== {8'd1, 8'd1, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_after: got cnt0=%0d run=%0d max=%0d det=%b want 1 1 1 0", a0, arun, amax, adet);
    end
  endtask
  task automatic test_async_reset();
    do_clr();
    beat(2'b11); beat(2'b01);
    #2 rst_b = 1'b0;
    #1;
    n_cmp++;
    if ({a0, a1, a2, a3, arun, amax, adet, adc, ast} !== '0) begin
      n_fail++;
      $display("FAIL arst: got %h want 0", {a0, a1, a2, a3, arun, amax, adet, adc, ast});
    end
    idle(1);
    rst_b = 1'b1;
    beat(2'b00);
    n_cmp++;
    if ({adet, adc, a0, arun} !== {1'b0, 8'd0, 8'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL arst_after: got det=%b cnt=%0d cnt0=%0d run=%0d want 0 0 1 1", adet, adc, a0, arun);
    end
  endtask
  task automatic test_back_to_back();
    int pulses = 0;
    do_clr();
    for (int i = 0; i < 16; i++) begin
      beat(2'b11);
      pulses += int'(adet);
      beat(2'b01);
      pulses += int'(adet);
      beat(2'b00);
      n_cmp++;
      if ({adet, bdet} !== 2'b11) begin
        n_fail++;
        $display("FAIL b2b_det[%0d]: got det8=%b det4=%b want 1 1", i, adet, bdet);
      end
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL b2b_extra: got %0d stray pulses want 0", pulses);
    end
    n_cmp++;
    if ({adc, bdc} !== {8'd16, 4'd15}) begin
      n_fail++;
      $display("FAIL b2b_cnt: got det_cnt8=%0d det_cnt4=%0d want 16 15", adc, bdc);
    end
    n_cmp++;
    if ({a3, a1, a0, amax} !== {8'd16, 8'd16, 8'd16, 8'd1}) begin
      n_fail++;
      $display("FAIL b2b_stats: got %0d %0d %0d max=%0d want 16 16 16 1", a3, a1, a0, amax);
    end
  endtask
  initial begin
    test_reset();
    test_truth_table();
    test_detect_gaps();
    test_no_detect();
    test_saturation();
    test_clr_priority();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
